// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer.
// Contents:
//   - ALU control codes driven while an operation executes.
//   - Request opcode encodings.
//   - FSM state encoding.
//   - Small helpers that decode a request opcode.
package muldiv_hilo_ctrl_pkg;

  localparam logic [3:0] ALU_NOP   = 4'h0;
  localparam logic [3:0] ALU_MULTU = 4'hC;
  localparam logic [3:0] ALU_DIVU  = 4'hD;
  localparam logic [3:0] ALU_MULT  = 4'hE;
  localparam logic [3:0] ALU_DIV   = 4'hF;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } req_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Map a request opcode to the ALU control code held during EXEC.
  function automatic logic [3:0] alu_code(input req_op_e op);
    logic [3:0] code;
    case (op)
      OP_MULTU: code = ALU_MULTU;
      OP_DIVU:  code = ALU_DIVU;
      OP_MULT:  code = ALU_MULT;
      OP_DIV:   code = ALU_DIV;
      default:  code = ALU_NOP;
    endcase
    return code;
  endfunction

  // Bit 0 of the opcode separates divides from multiplies.
  function automatic logic op_is_div(input req_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO register pair.
// Ports:
//   clk, rst_n        clock and asynchronous active-low clear
//   hi_we_i, lo_we_i  independent write enables
//   hi_d_i, lo_d_i    write data
//   hi_o, lo_o        current register contents
module muldiv_hilo_ctrl_hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] hi_d_i,
  input  logic [WIDTH-1:0] lo_d_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // NOTE: HI/LO are two architectural flops, not a RAM array, so they take
  // the async clear; software may read them straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= hi_d_i;
      if (lo_we_i) lo_q <= lo_d_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle sequencer for the mult/div half of the shared ALU.
// Accepts one MULT/MULTU/DIV/DIVU request at a time. It holds the operands
// and the ALU control code steady for a fixed latency. It then commits the
// ALU result into HI/LO. MTHI/MTLO writes are taken only while idle.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_op        request handshake and opcode (00 MULTU, 01 DIVU,
//                           10 MULT, 11 DIV)
//   rs_val, rt_val          operands (dividend/multiplicand, divisor/multiplier)
//   req_ready               high in IDLE; request taken on valid && ready
//   flush                   abandon any in-flight operation, block new accepts
//   mt_hi_we/mt_lo_we       MTHI/MTLO write enables
//   mt_data                 MTHI/MTLO write data
//   mf_req                  MFHI/MFLO read in EX this cycle
//   hi_out, lo_out          current HI/LO
//   stall                   freeze the pipeline front end
//   alu_in1/alu_in2         operands to the shared ALU
//   alu_ctrl                control code to the shared ALU
//   alu_out1, alu_out2      ALU results (LO/quotient, HI/remainder)
//   alu_o                   ALU overflow flag
//   done                    one-cycle pulse: result committed or divide by zero
//   dz_exc                  one-cycle divide-by-zero pulse, coincident with done
module muldiv_hilo_ctrl
  import muldiv_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             req_ready,
  input  logic             flush,
  input  logic             mt_hi_we,
  input  logic             mt_lo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             stall,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out1,
  input  logic [WIDTH-1:0] alu_out2,
  input  logic             alu_o,
  output logic             done,
  output logic             dz_exc
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  req_op_e          op_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;
  logic [3:0]       ctrl_q;
  logic             done_q;
  logic             dz_q;

  req_op_e          op_in;
  logic [CNT_W-1:0] lat_load;
  logic             idle;
  logic             exec;
  logic             accept;
  logic             commit;
  logic             div_by_zero;
  logic             res_we;
  logic             mt_ok;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // The overflow flag is irrelevant to mult/div, including divide by zero.
  logic unused_alu_o;
  assign unused_alu_o = alu_o;

  assign op_in    = req_op_e'(req_op);
  assign lat_load = op_is_div(op_in) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign cnt_d    = cnt_q - CNT_W'(1);

  assign idle   = (state_q == ST_IDLE);
  assign exec   = (state_q == ST_EXEC);
  // A flush blocks a same-cycle accept and overrides a same-cycle commit.
  assign accept = idle && req_valid && !flush;
  assign commit = exec && !flush && (cnt_q == '0);

  // Divide by zero is judged on the latched divisor, not the live rt_val.
  assign div_by_zero = commit && op_is_div(op_q) && (rt_q == '0);
  assign res_we      = commit && !div_by_zero;

  // MTHI/MTLO only while idle and not taking a request. In EXEC the pipeline
  // is stalled and the move is re-presented later. res_we and mt_ok are
  // mutually exclusive (EXEC vs IDLE), so the data muxes need no priority.
  assign mt_ok = idle && !accept;
  assign hi_we = res_we || (mt_ok && mt_hi_we);
  assign lo_we = res_we || (mt_ok && mt_lo_we);
  assign hi_d  = res_we ? alu_out2 : mt_data;
  assign lo_d  = res_we ? alu_out1 : mt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULTU;
      rs_q    <= '0;
      rt_q    <= '0;
      ctrl_q  <= ALU_NOP;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_EXEC;
            op_q    <= op_in;
            rs_q    <= rs_val;
            rt_q    <= rt_val;
            ctrl_q  <= alu_code(op_in);
            cnt_q   <= lat_load;
          end
        end
        ST_EXEC: begin
          if (flush || cnt_q == '0) begin
            // Clearing the latches on exit drives zeros to the ALU in IDLE.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            ctrl_q  <= ALU_NOP;
            done_q  <= commit;
            dz_q    <= div_by_zero;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  muldiv_hilo_ctrl_hilo_regs #(
    .WIDTH(WIDTH)
  ) u_hilo_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .hi_d_i  (hi_d),
    .lo_d_i  (lo_d),
    .hi_o    (hi_out),
    .lo_o    (lo_out)
  );

  assign req_ready = idle;
  // Stall in IDLE only for the illegal req_valid+mf_req combination.
  assign stall     = exec || (req_valid && mf_req);
  assign alu_in1   = rs_q;
  assign alu_in2   = rt_q;
  assign alu_ctrl  = ctrl_q;
  assign done      = done_q;
  assign dz_exc    = dz_q;

endmodule
